soc_system_fifo_stream_buffer: RTL

Single-clock show-ahead FIFO that buffers the data stream ahead of the FIFO consumer logic. It also produces the 1-bit `fifo_flag` status that drives the `in_port` of the FIFO-monitor PIO, so software can poll buffer pressure over Avalon. The write side is an Avalon-ST-style valid/ready sink, the read side a valid/ready source. It also provides a fill-level output, a sticky overflow bit and a synchronous flush.

---
 rtl/soc_system_fifo_stream_buffer_if.sv | 30 +++
 rtl/soc_system_fifo_stream_buffer.sv | 110 +++++++++++
 2 files changed

// File: rtl/soc_system_fifo_stream_buffer_if.sv
// Stream handshake bundle for the FIFO stream buffer: write-side sink and read-side source.
// The FIFO uses the slave view; the producer/consumer side uses the master view.
interface soc_system_fifo_stream_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/soc_system_fifo_stream_buffer.sv
// Single-clock show-ahead FIFO with registered level, sticky overflow, flush, and a
// registered almost-full/overflow status flag for the FIFO-monitor PIO.
module soc_system_fifo_stream_buffer #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned DEPTH_LOG2        = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    soc_system_fifo_stream_buffer_if.slave stream,
    input  logic                           flush,
    input  logic                           clear_overflow,
    output logic [DEPTH_LOG2:0]            level,
    output logic                           overflow,
    output logic                           fifo_flag
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LevelFull = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LevelAf   = (DEPTH_LOG2 + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [DEPTH_LOG2:0]   LevelOne  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  almost_full_q, almost_full_d;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    assign full  = (level_q == LevelFull);
    assign empty = (level_q == '0);

    assign stream.in_ready  = !full && !flush;
    assign stream.out_valid = !empty;
    assign stream.out_data  = mem_q[rd_ptr_q];

    assign wr_en = stream.in_valid && stream.in_ready;
    // A read presented during flush is dropped, so the head is not consumed.
    assign rd_en = stream.out_valid && stream.out_ready && !flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        overflow_d    = overflow_q;
        almost_full_d = almost_full_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LevelOne;
                2'b01:   level_d = level_q - LevelOne;
                default: level_d = level_q;
            endcase
        end

        // Set has priority over clear; flush never touches the sticky bit.
        if (stream.in_valid && !stream.in_ready) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        almost_full_d = (level_d >= LevelAf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= stream.in_data;
        end
    end

    assign level     = level_q;
    assign overflow  = overflow_q;
    assign fifo_flag = almost_full_q || overflow_q;

endmodule
